// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the pong game sequencer
//
// Purpose: game_state encoding, score width and winner codes used by
//          pong_game_ctrl and its testbench-visible outputs.
// Ports:   none (package).
package pong_pkg;

   localparam int SCORE_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_POINT_P1  = 3'd4,
      ST_POINT_P2  = 3'd5,
      ST_GAME_OVER = 3'd6
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/pulse_divider.sv
// rtl/pulse_divider.sv - enable-driven counter emitting a pulse every limit enables
//
// Purpose: counts cycles where enable is high; pulse is high on the enable
//          that completes a run of limit counts, and the count wraps to 0.
// Ports:   clock, reset (async active-low), enable, clear (sync, wins over
//          enable), limit [W-1:0], pulse (combinational, one cycle wide).
module pulse_divider #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   input  logic [W-1:0] limit,
   output logic         pulse
);

   logic [W-1:0] count;
   logic         at_end;

   // >= rather than == so a limit that shrinks below the current count
   // wraps on the next enable instead of running the counter round.
   assign at_end = (count >= (limit - W'(1)));
   assign pulse  = enable & at_end;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= at_end ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: serve/play/pause/score/game-over
//
// Purpose: drives ball_reset and ball_step for the ball datapath, detects
//          goals on ball_y, keeps scores and the winner.
// Ports:   clock, reset (async active-low), frame_tick, start_btn, ball_y[8:0],
//          ball_x[7:0] (status only), ball_reset, ball_step, score_p1[3:0],
//          score_p2[3:0], game_state[2:0], winner[1:0].
// Option:  PONG_SPEEDUP_EN - shorten the step interval by one frame every
//          RALLY_FRAMES frames of play (floor 1), restored at each serve.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter logic [7:0]         SERVE_FRAMES = 8'd60,
   parameter logic [3:0]         STEP_DIV     = 4'd4,
   parameter logic [8:0]         GOAL_LO      = 9'd20,
   parameter logic [8:0]         GOAL_HI      = 9'd300,
   parameter logic [SCORE_W-1:0] WIN_SCORE    = 4'd9,
   parameter logic [9:0]         RALLY_FRAMES = 10'd600
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic [8:0]         ball_y,
   input  logic [7:0]         ball_x,
   output logic               ball_reset,
   output logic               ball_step,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [2:0]         game_state,
   output logic [1:0]         winner
);

   state_t             state;
   logic               start_prev;
   logic               start_pulse;
   logic [3:0]         cur_div;
   logic               in_play;
   logic               goal_lo;
   logic               goal_hi;
   logic               run_tick;
   logic               serve_done;
   logic               step_wrap;
   logic [SCORE_W-1:0] p1_inc;
   logic [SCORE_W-1:0] p2_inc;
   logic               unused_ok;

   assign unused_ok  = ^{ball_x, RALLY_FRAMES};
   assign game_state = state;
   assign in_play    = (state == ST_PLAY);
   assign goal_lo    = (ball_y <= GOAL_LO);
   assign goal_hi    = (ball_y >= GOAL_HI);
   // In PLAY a goal beats a pause request, which beats a frame tick.
   assign run_tick   = in_play & frame_tick & ~goal_lo & ~goal_hi & ~start_pulse;
   assign p1_inc     = score_p1 + SCORE_W'(1);
   assign p2_inc     = score_p2 + SCORE_W'(1);

   pulse_divider #(.W(8)) u_serve_div (
      .clock  (clock),
      .reset  (reset),
      .enable (state == ST_SERVE && frame_tick),
      .clear  (state != ST_SERVE),
      .limit  (SERVE_FRAMES),
      .pulse  (serve_done)
   );

   // Held (not cleared) through PAUSE so stepping resumes mid-interval.
   pulse_divider #(.W(4)) u_step_div (
      .clock  (clock),
      .reset  (reset),
      .enable (run_tick),
      .clear  (state != ST_PLAY && state != ST_PAUSE),
      .limit  (cur_div),
      .pulse  (step_wrap)
   );

`ifdef PONG_SPEEDUP_EN
   logic rally_wrap;

   pulse_divider #(.W(10)) u_rally_div (
      .clock  (clock),
      .reset  (reset),
      .enable (run_tick),
      .clear  (state == ST_SERVE),
      .limit  (RALLY_FRAMES),
      .pulse  (rally_wrap)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur_div <= STEP_DIV;
      end else if (state == ST_SERVE) begin
         cur_div <= STEP_DIV;
      end else if (rally_wrap && cur_div > 4'd1) begin
         cur_div <= cur_div - 4'd1;
      end
   end
`else
   assign cur_div = STEP_DIV;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         ball_reset  <= 1'b1;
         ball_step   <= 1'b0;
         score_p1    <= '0;
         score_p2    <= '0;
         winner      <= WIN_NONE;
         start_prev  <= 1'b0;
         start_pulse <= 1'b0;
      end else begin
         start_prev  <= start_btn;
         start_pulse <= start_btn & ~start_prev;
         ball_step   <= step_wrap;
         case (state)
            ST_IDLE: begin
               if (start_pulse) begin
                  state    <= ST_SERVE;
                  score_p1 <= '0;
                  score_p2 <= '0;
               end
            end
            ST_SERVE: begin
               if (serve_done) begin
                  state      <= ST_PLAY;
                  ball_reset <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (goal_lo) begin
                  state      <= ST_POINT_P2;
                  ball_reset <= 1'b1;
               end else if (goal_hi) begin
                  state      <= ST_POINT_P1;
                  ball_reset <= 1'b1;
               end else if (start_pulse) begin
                  state <= ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start_pulse) begin
                  state <= ST_PLAY;
               end
            end
            ST_POINT_P1: begin
               score_p1 <= p1_inc;
               if (p1_inc == WIN_SCORE) begin
                  state  <= ST_GAME_OVER;
                  winner <= WIN_P1;
               end else begin
                  state <= ST_SERVE;
               end
            end
            ST_POINT_P2: begin
               score_p2 <= p2_inc;
               if (p2_inc == WIN_SCORE) begin
                  state  <= ST_GAME_OVER;
                  winner <= WIN_P2;
               end else begin
                  state <= ST_SERVE;
               end
            end
            ST_GAME_OVER: begin
               if (start_pulse) begin
                  state    <= ST_SERVE;
                  score_p1 <= '0;
                  score_p2 <= '0;
                  winner   <= WIN_NONE;
               end
            end
            default: begin
               state      <= ST_IDLE;
               ball_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized self-checking bench for pong_game_ctrl
//
// Purpose: drives random frame ticks, start presses and ball positions and
//          compares every output each cycle against a frame-level game model.
// Ports:   none (top-level bench). Honours PONG_SPEEDUP_EN when defined.
module tb_pong_game_ctrl;

   localparam int SERVE_N = 60;
   localparam int DIV     = 4;
   localparam int LO      = 20;
   localparam int HI      = 300;
   localparam int WIN     = 9;
   localparam int RALLY   = 10;
   localparam int CYCLES  = 30000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic [8:0] ball_y = 9'd150;
   logic [7:0] ball_x = 8'd0;
   logic       ball_reset;
   logic       ball_step;
   logic [3:0] score_p1;
   logic [3:0] score_p2;
   logic [2:0] game_state;
   logic [1:0] winner;

   always #5 clock = ~clock;

   pong_game_ctrl #(
      .SERVE_FRAMES (8'd60),
      .STEP_DIV     (4'd4),
      .GOAL_LO      (9'd20),
      .GOAL_HI      (9'd300),
      .WIN_SCORE    (4'd9),
      .RALLY_FRAMES (10'd10)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start_btn  (start_btn),
      .ball_y     (ball_y),
      .ball_x     (ball_x),
      .ball_reset (ball_reset),
      .ball_step  (ball_step),
      .score_p1   (score_p1),
      .score_p2   (score_p2),
      .game_state (game_state),
      .winner     (winner)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
   endtask

   // Game model: mode numbers follow the published game_state encoding.
   int m_mode, m_p1, m_p2, m_win, m_reset, m_step;
   int m_serve_ticks, m_play_ticks, m_rally_ticks, m_interval;
   bit m_prev_btn, m_press;

   task automatic model_reset();
      m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_reset = 1; m_step = 0;
      m_serve_ticks = 0; m_play_ticks = 0; m_rally_ticks = 0; m_interval = DIV;
      m_prev_btn = 0; m_press = 0;
   endtask

   task automatic model_step(input bit tick, input bit btn, input int y);
      bit press;
      press = m_press;
      m_press = btn && !m_prev_btn;
      m_prev_btn = btn;
      m_step = 0;
      if (m_mode != 1) m_serve_ticks = 0;
      if (m_mode != 2 && m_mode != 3) m_play_ticks = 0;
      case (m_mode)
         0: if (press) begin m_mode = 1; m_p1 = 0; m_p2 = 0; end
         1: begin
            m_interval = DIV;
            m_rally_ticks = 0;
            if (tick) begin
               m_serve_ticks++;
               if (m_serve_ticks == SERVE_N) m_mode = 2;
            end
         end
         2: begin
            if (y <= LO) m_mode = 5;
            else if (y >= HI) m_mode = 4;
            else if (press) m_mode = 3;
            else if (tick) begin
               m_play_ticks++;
               if (m_play_ticks >= m_interval) begin
                  m_step = 1;
                  m_play_ticks = 0;
               end
`ifdef PONG_SPEEDUP_EN
               m_rally_ticks++;
               if (m_rally_ticks == RALLY) begin
                  m_rally_ticks = 0;
                  if (m_interval > 1) m_interval--;
               end
`endif
            end
         end
         3: if (press) m_mode = 2;
         4: begin
            m_p1++;
            if (m_p1 == WIN) begin m_mode = 6; m_win = 1; end
            else m_mode = 1;
         end
         5: begin
            m_p2++;
            if (m_p2 == WIN) begin m_mode = 6; m_win = 2; end
            else m_mode = 1;
         end
         6: if (press) begin m_mode = 1; m_p1 = 0; m_p2 = 0; m_win = 0; end
         default: m_mode = 0;
      endcase
      m_reset = (m_mode == 2 || m_mode == 3) ? 0 : 1;
   endtask

   task automatic check_all(input string pfx);
      check({pfx, "_state"},      int'(game_state), m_mode);
      check({pfx, "_ball_reset"}, int'(ball_reset), m_reset);
      check({pfx, "_ball_step"},  int'(ball_step),  m_step);
      check({pfx, "_score_p1"},   int'(score_p1),   m_p1);
      check({pfx, "_score_p2"},   int'(score_p2),   m_p2);
      check({pfx, "_winner"},     int'(winner),     m_win);
   endtask

   // Called just after a checked posedge; returns at a negedge.
   task automatic async_reset();
      #2 reset = 1'b0;
      start_btn = 1'b0;
      #1;
      model_reset();
      check_all("rst");
      @(negedge clock);
      reset = 1'b1;
   endtask

   int btn_left = 0;
   int r;
   int max_p1 = 0, max_p2 = 0;

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #1 check_all("init");
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < CYCLES; i++) begin
         cyc = i;
         frame_tick = ($urandom_range(0, 3) == 0);
         if (btn_left > 0) begin
            start_btn = 1'b1;
            btn_left--;
         end else begin
            start_btn = 1'b0;
            if ($urandom_range(0, 249) == 0) btn_left = $urandom_range(1, 4);
         end
         r = $urandom_range(0, 399);
         case (r)
            0: ball_y = 9'(LO);
            1: ball_y = 9'(HI);
            2: ball_y = 9'($urandom_range(0, LO));
            3: ball_y = 9'($urandom_range(HI, 511));
            4: ball_y = 9'(LO + 1);
            5: ball_y = 9'(HI - 1);
            default: ball_y = 9'($urandom_range(LO + 1, HI - 1));
         endcase
         ball_x = 8'($urandom);
         model_step(frame_tick, start_btn, int'(ball_y));
         @(posedge clock);
         #1 check_all("run");
         if (m_p1 > max_p1) max_p1 = m_p1;
         if (m_p2 > max_p2) max_p2 = m_p2;
         if (i == 9000 || i == 21000) async_reset();
         else @(negedge clock);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for Pong. It drives the ball's synchronous reset and a per-step enable. It detects goals from the ball's vertical (play-axis) position and keeps both players' scores. It also runs the idle/serve/play/pause/game-over flow from a single start button and a frame-rate tick.

Parameters:
SERVE_FRAMES, 8'd60, frames ball is held at start position before play resumes
STEP_DIV, 4'd4, frames per ball step at base speed (min 1)
GOAL_LO, 9'd20, ball_y at or below this = goal against player 1 (player 2 scores)
GOAL_HI, 9'd300, ball_y at or above this = goal against player 2 (player 1 scores)
WIN_SCORE, 4'd9, score that ends the game
RALLY_FRAMES, 10'd600, frames of continuous play per speed-up step (used only with SPEEDUP_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
start_btn  in  1  debounced start/pause button, level
ball_y  in  9  ball vertical position
ball_x  in  8  ball horizontal position (status only, unused in goal logic)
ball_reset  out  1  active-high synchronous reset to ball datapath
ball_step  out  1  one-cycle clock enable for ball datapath
score_p1  out  4  player 1 score
score_p2  out  4  player 2 score
game_state  out  3  encoded FSM state for display logic
winner  out  2  0 none, 1 player 1, 2 player 2

Behaviour:
- Reset (reset=0, async): state IDLE, ball_reset=1, ball_step=0, scores=0, winner=0, all counters 0, start edge register cleared.
- start edge: rising edge of start_btn, registered; start_pulse valid one cycle after the button rises.
- IDLE: ball_reset=1. start_pulse -> SERVE; scores cleared.
- SERVE: ball_reset=1; serve counter counts frame_tick. At count SERVE_FRAMES-1 with frame_tick -> PLAY, counter cleared.
- PLAY: ball_reset=0. Divider counts frame_tick to cur_div-1, then wraps. ball_step=1 in the cycle after the wrapping frame_tick, exactly one cycle wide.
- Goal check in PLAY, registered on current ball_y:
  - ball_y<=GOAL_LO -> POINT_P2.
  - ball_y>=GOAL_HI -> POINT_P1.
  - Goal has priority over a same-cycle frame_tick: no step issued.
- Pause in PLAY: start_pulse -> PAUSE. ball_step held 0, divider frozen. start_pulse -> PLAY with divider resumed.
- Priority in PLAY: goal over pause.
- POINT_P1 / POINT_P2 (one cycle each):
  - Increment the scoring player's score (4-bit; never exceeds WIN_SCORE).
  - If the new score == WIN_SCORE -> GAME_OVER with winner set; else -> SERVE.
  - ball_reset=1 from this cycle onward.
- GAME_OVER: ball_reset=1, scores and winner held. start_pulse -> SERVE with scores=0, winner=0.
- frame_tick ignored in IDLE, PAUSE, POINT_*, GAME_OVER.
- cur_div = STEP_DIV unless SPEEDUP_EN.
- Mid-operation reset returns to IDLE immediately regardless of state.
- All outputs registered; game_state encoding: IDLE 0, SERVE 1, PLAY 2, PAUSE 3, POINT_P1 4, POINT_P2 5, GAME_OVER 6.

Optional Feature:
PONG_SPEEDUP_EN
- Defined:
  - Rally counter counts frame_tick in PLAY only.
  - Each RALLY_FRAMES, cur_div decrements by 1, floor 1.
  - Rally counter and cur_div restore to 0 and STEP_DIV on entering SERVE.
- Undefined: no rally counter; cur_div is constant STEP_DIV; RALLY_FRAMES is unused.

Decomposition:
- pong_pkg: game_state encoding constants, SCORE_W=4, winner codes.
- Sub-module pulse_divider: enable, clear, count limit in; one-cycle pulse out. Used for both the serve countdown and the step divider.

Test Plan:
- reset low mid-PLAY with scores 3/2 -> same cycle game_state=0, ball_reset=1, scores 0/0.
- start pulse, SERVE_FRAMES=60, frame_tick every 4 cycles -> PLAY entered after the 60th tick; ball_step pulses exactly every 4 frame_ticks (STEP_DIV=4), one cycle wide.
- PLAY, drive ball_y=9'd20 -> POINT_P2 next cycle, score_p2 increments by 1, back to SERVE with ball_reset=1.
- ball_y=9'd300 on the same cycle as a frame_tick that would wrap the divider -> no ball_step, score_p1 increments.
- score_p1=8, goal at GOAL_HI -> score_p1=9, game_state=6, winner=1. Further goals and frame_ticks are ignored. start_pulse -> SERVE with 0/0.
- PLAY, start pulse -> PAUSE with no ball_step for 20 frames; second pulse -> PLAY and divider resumes from its frozen count.
- With PONG_SPEEDUP_EN and RALLY_FRAMES=10, STEP_DIV=4 -> step interval shrinks 4, 3, 2, 1, 1 frames at each 10-frame boundary; restores to 4 after a goal.
